led_pattern_engine: RTL

Parametrised LED pattern generator for the lab board's dual-colour LED bar: successor to the fixed 8-bit red-only scroller. It divides the board clock to a step tick and drives a WIDTH-bit red and green channel with one of four run-time selectable patterns: rotate left, rotate right, bounce and fill/clear. It sits directly below the lab top level and connects straight to the LED pins.

---
 rtl/led_pkg.sv | 9 +
 rtl/led_pattern_engine_tick_gen.sv | 35 +++
 rtl/led_pattern_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern engine: run-time pattern select codes.
package led_pkg;

   localparam logic [1:0] MODE_ROT_L  = 2'd0;
   localparam logic [1:0] MODE_ROT_R  = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_FILL   = 2'd3;

endpackage

// File: rtl/led_pattern_engine_tick_gen.sv
// Free-running step divider for the LED pattern engine; freezes while paused.
// Optional LED_SPEED_SEL_EN adds a speed input that shortens the tick period.
module tick_gen #(
   parameter int DIV_BITS = 20
) (
   input  logic       clk,
   input  logic       reset,
`ifdef LED_SPEED_SEL_EN
   input  logic [1:0] speed,
`endif
   input  logic       pause,
   output logic       tick
);

   logic [DIV_BITS-1:0] count;
   logic [DIV_BITS-1:0] mask;

`ifdef LED_SPEED_SEL_EN
   // Only the low DIV_BITS-speed bits must be all ones, dividing the period by 2^speed
   assign mask = {DIV_BITS{1'b1}} >> speed;
`else
   assign mask = {DIV_BITS{1'b1}};
`endif

   assign tick = !pause && ((count & mask) == mask);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (!pause) begin
         count <= count + DIV_BITS'(1);
      end
   end

endmodule

// File: rtl/led_pattern_engine.sv
// Dual-colour LED bar pattern generator: rotate left/right, bounce, fill/clear.
// Optional LED_SPEED_SEL_EN adds a speed[1:0] input forwarded to the divider.
module led_pattern_engine
   import led_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIV_BITS = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             pause,
`ifdef LED_SPEED_SEL_EN
   input  logic [1:0]       speed,
`endif
   output logic [WIDTH-1:0] shiftR_out,
   output logic [WIDTH-1:0] shiftG_out,
   output logic             ctl_bit
);

   localparam logic [WIDTH-1:0] PAT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             tick;
   logic [WIDTH-1:0] pat, pat_nxt;
   logic             dir, dir_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic [WIDTH-1:0] red_nxt, grn_nxt;

   tick_gen #(
      .DIV_BITS (DIV_BITS)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
`ifdef LED_SPEED_SEL_EN
      .speed (speed),
`endif
      .pause (pause),
      .tick  (tick)
   );

   assign ctl_bit = 1'b1;

   // State and output registers; outputs load from next-state so they move with pat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat        <= PAT_ONE;
         dir        <= 1'b0;
         mode_q     <= MODE_ROT_L;
         shiftR_out <= PAT_ONE;
         shiftG_out <= '0;
      end else begin
         pat        <= pat_nxt;
         dir        <= dir_nxt;
         mode_q     <= mode_nxt;
         shiftR_out <= red_nxt;
         shiftG_out <= grn_nxt;
      end
   end

   always_comb begin
      pat_nxt  = pat;
      dir_nxt  = dir;
      mode_nxt = mode_q;
      if (tick) begin
         if (mode != mode_q) begin
            // A newly selected pattern starts from its seed instead of stepping
            mode_nxt = mode;
            dir_nxt  = 1'b0;
            pat_nxt  = (mode == MODE_FILL) ? '0 : PAT_ONE;
         end else begin
            case (mode_q)
               MODE_ROT_L: begin
                  pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
                  dir_nxt = 1'b0;
               end
               MODE_ROT_R: begin
                  pat_nxt = {pat[0], pat[WIDTH-1:1]};
                  dir_nxt = 1'b1;
               end
               MODE_BOUNCE: begin
                  if (!dir) begin
                     if (pat[WIDTH-1]) begin
                        dir_nxt = 1'b1;
                        pat_nxt = pat >> 1;
                     end else begin
                        pat_nxt = pat << 1;
                     end
                  end else if (pat[0]) begin
                     dir_nxt = 1'b0;
                     pat_nxt = pat << 1;
                  end else begin
                     pat_nxt = pat >> 1;
                  end
               end
               default: begin
                  // Fill shifts ones in until full, then clears by shifting zeros in
                  if (!dir) begin
                     if (&pat) begin
                        dir_nxt = 1'b1;
                        pat_nxt = {pat[WIDTH-2:0], 1'b0};
                     end else begin
                        pat_nxt = {pat[WIDTH-2:0], 1'b1};
                     end
                  end else if (pat == '0) begin
                     dir_nxt = 1'b0;
                     pat_nxt = {pat[WIDTH-2:0], 1'b1};
                  end else begin
                     pat_nxt = {pat[WIDTH-2:0], 1'b0};
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      red_nxt = dir_nxt ? '0 : pat_nxt;
      grn_nxt = dir_nxt ? pat_nxt : '0;
   end

endmodule
